// File: rtl/rv32_fetch_pkg.sv
// rv32_fetch_pkg: opcodes, fetch buffer entry layout and immediate decoders shared by the fetch unit
package rv32_fetch_pkg;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } fetch_entry_t;
  localparam int ENTRY_W = $bits(fetch_entry_t);
  function automatic logic [31:0] j_imm(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction
  function automatic logic [31:0] b_imm(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular buffer with first-word fall-through head and synchronous flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 65
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    rd_d = flush ? '0 : rd_q + AW'(pop);
    wr_d = flush ? '0 : wr_q + AW'(push);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing 1-cycle-latency word reads into a small buffer for decode.
// Define PREDICT_EN to steer fetch through JAL and backward branches via the predict port.
module instr_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_renable,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addrpred,
  input  logic [31:0] mem_rdata_pred,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_pred_taken
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d, next_pc;
  logic inflight_q, inflight_d, inflight_pred_q, inflight_pred_d;
  logic taken, pop, push;
  logic [CW-1:0] count;
  fetch_entry_t head, entry_in;
`ifdef PREDICT_EN
  logic is_jal, is_bwd;
  logic [31:0] tgt;
  assign mem_addrpred = pc_q;
  assign is_jal = mem_rdata_pred[6:0] == OPC_JAL;
  assign is_bwd = mem_rdata_pred[6:0] == OPC_BRANCH && mem_rdata_pred[31];
  assign taken = is_jal || is_bwd;
  assign tgt = pc_q + (is_jal ? j_imm(mem_rdata_pred) : b_imm(mem_rdata_pred));
  assign next_pc = taken ? {tgt[31:2], 2'b00} : pc_q + 32'd4;
`else
  logic unused_pred;
  assign unused_pred = ^mem_rdata_pred;
  assign mem_addrpred = '0;
  assign taken = 1'b0;
  assign next_pc = pc_q + 32'd4;
`endif
  assign pop = if_valid && if_ready;
  // The inflight read returning in a redirect cycle is stale and is dropped here.
  assign push = inflight_q && !redirect_valid;
  assign mem_renable = !rst && !redirect_valid &&
                       (int'(count) + int'(inflight_q) - int'(pop)) < FIFO_DEPTH;
  assign mem_addr = pc_q;
  assign entry_in = '{instr: mem_rdata, pc: inflight_pc_q, pred: inflight_pred_q};
  always_comb begin
    pc_d = pc_q;
    inflight_d = 1'b0;
    inflight_pc_d = inflight_pc_q;
    inflight_pred_d = inflight_pred_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (mem_renable) begin
      inflight_d = 1'b1;
      inflight_pc_d = pc_q;
      inflight_pred_d = taken;
      pc_d = next_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
      inflight_pred_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_pred_q <= inflight_pred_d;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect_valid),
    .push (push),
    .pop  (pop),
    .din  (entry_in),
    .dout (head),
    .count(count)
  );
  assign if_valid = count != '0;
  assign if_instr = if_valid ? head.instr : NOP_INSTR;
  assign if_pc = if_valid ? head.pc : '0;
  assign if_pred_taken = if_valid && head.pred;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus with a delivery scoreboard for instr_fetch_unit
module tb_instr_fetch_unit;
  logic clk = 0;
  logic rst, if_ready, redirect_valid, jal_en;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr, mem_rdata, mem_addrpred, mem_rdata_pred, if_instr, if_pc;
  logic mem_renable, if_valid, if_pred_taken;
  logic [64:0] sb[$];
  int n_assert = 0;
  int n_fail = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_renable(mem_renable),
    .mem_rdata(mem_rdata), .mem_addrpred(mem_addrpred), .mem_rdata_pred(mem_rdata_pred),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc), .if_pred_taken(if_pred_taken)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    if (a == 32'h4) return 32'h00A00113;
    if (a == 32'h10 && jal_en) return 32'hFF1FF06F;
    return {a[24:0], 7'h13};
  endfunction

  initial mem_rdata = '0;
  always @(posedge clk) if (mem_renable) mem_rdata <= mem_word(mem_addr);
  assign mem_rdata_pred = mem_word(mem_addrpred);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc, input logic pred);
    sb.push_back({mem_word(pc), pc, pred});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    if (!rst && if_valid && if_ready && sb.size() > 0) begin
      logic [64:0] e;
      e = sb.pop_front();
      chk("pop_pc", if_pc, e[32:1]);
      chk("pop_instr", if_instr, e[64:33]);
      chk("pop_pred", {31'b0, if_pred_taken}, {31'b0, e[0]});
    end
  end

  initial begin
    rst = 1; if_ready = 1; redirect_valid = 0; redirect_pc = '0; jal_en = 0;
    steps(2);
    chk("rst_renable", {31'b0, mem_renable}, 0);
    chk("rst_valid", {31'b0, if_valid}, 0);
    chk("rst_instr", if_instr, 32'h0000_0013);
    chk("rst_pc", if_pc, 0);
    chk("rst_pred", {31'b0, if_pred_taken}, 0);
    // startup latency and steady streaming
    exp_push(32'h0, 0); exp_push(32'h4, 0);
    rst = 0; #1;
    chk("c1_renable", {31'b0, mem_renable}, 1);
    chk("c1_addr", mem_addr, 32'h0);
    chk("c1_valid", {31'b0, if_valid}, 0);
    step();
    chk("c2_renable", {31'b0, mem_renable}, 1);
    chk("c2_addr", mem_addr, 32'h4);
    chk("c2_valid", {31'b0, if_valid}, 0);
    step();
    chk("c3_valid", {31'b0, if_valid}, 1);
    chk("c3_pc", if_pc, 32'h0);
    chk("c3_renable", {31'b0, mem_renable}, 1);
    chk("c3_addr", mem_addr, 32'h8);
    step();
    chk("c4_pc", if_pc, 32'h4);
    chk("c4_renable", {31'b0, mem_renable}, 1);
    step();
    chk("p1_drain", sb.size(), 0);
    // back-pressure from reset
    rst = 1; if_ready = 0;
    step();
    exp_push(32'h0, 0); exp_push(32'h4, 0); exp_push(32'h8, 0); exp_push(32'hC, 0);
    rst = 0; #1;
    steps(2);
    chk("stall_valid", {31'b0, if_valid}, 1);
    chk("stall_c3_renable", {31'b0, mem_renable}, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_renable", {31'b0, mem_renable}, 0);
      chk("stall_pc", if_pc, 32'h0);
      chk("stall_instr", if_instr, 32'h00500093);
      if (i < 2) step();
    end
    step();
    if_ready = 1; #1;
    chk("release_renable", {31'b0, mem_renable}, 1);
    chk("release_addr", mem_addr, 32'h8);
    steps(6);
    chk("p2_drain", sb.size(), 0);
    // redirect while the read of 8 is inflight
    rst = 1;
    step();
    exp_push(32'h0, 0); exp_push(32'h4, 0); exp_push(32'h100, 0); exp_push(32'h104, 0);
    rst = 0; #1;
    steps(3);
    chk("pre_redir_addr", mem_addr, 32'hC);
    redirect_valid = 1; redirect_pc = 32'h100; #1;
    chk("redir_renable", {31'b0, mem_renable}, 0);
    step();
    redirect_valid = 0; #1;
    chk("redir_addr", mem_addr, 32'h100);
    chk("redir_renable2", {31'b0, mem_renable}, 1);
    chk("redir_valid", {31'b0, if_valid}, 0);
    steps(6);
    chk("p3_drain", sb.size(), 0);
    // misaligned redirect target
    redirect_valid = 1; redirect_pc = 32'h103;
    step();
    redirect_valid = 0;
    exp_push(32'h100, 0); exp_push(32'h104, 0);
    #1;
    chk("mis_addr", mem_addr, 32'h100);
    steps(6);
    chk("p4_drain", sb.size(), 0);
    // pc wrap at the top of the address space
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0;
    exp_push(32'hFFFF_FFFC, 0); exp_push(32'h0, 0); exp_push(32'h4, 0);
    #1;
    chk("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr1", mem_addr, 32'h0);
    steps(6);
    chk("p5_drain", sb.size(), 0);
    // JAL x0,-16 at 0x10
    jal_en = 1; redirect_valid = 1; redirect_pc = 32'h10;
    step();
    redirect_valid = 0;
`ifdef PREDICT_EN
    exp_push(32'h10, 1); exp_push(32'h0, 0);
`else
    exp_push(32'h10, 0); exp_push(32'h14, 0);
`endif
    #1;
    chk("jal_addr0", mem_addr, 32'h10);
    step();
`ifdef PREDICT_EN
    chk("jal_addr1", mem_addr, 32'h0);
`else
    chk("jal_addr1", mem_addr, 32'h14);
`endif
    steps(6);
    chk("p6_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch-side initiator for the instruction memory read bus. Owns the PC and issues word reads with 1-cycle read latency. Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake. Handles redirects from execute and, optionally, static prediction through the memory's combinational predict port.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2; 2 gives full throughput.

Ports:
clk  in  1  clock, all state on posedge.
rst  in  1  synchronous, active-high reset.
mem_addr  out  32  read address; equals the pc register; bits [1:0] always 0.
mem_renable  out  1  read request; data appears on mem_rdata one cycle later.
mem_rdata  in  32  registered read data.
mem_addrpred  out  32  predict-port address (PREDICT_EN only; else 0).
mem_rdata_pred  in  32  combinational predict-port data (ignored without PREDICT_EN).
redirect_valid  in  1  execute-stage PC override (branch, jump, mispredict).
redirect_pc  in  32  redirect target.
if_valid  out  1  instruction available to decode.
if_ready  in  1  decode accepts when if_valid && if_ready.
if_instr  out  32  instruction word.
if_pc  out  32  address of if_instr.
if_pred_taken  out  1  fetch predicted this instruction taken.

Behaviour:
- Reset: pc=RESET_PC, inflight=0, FIFO empty.
  - Outputs during/after reset: mem_renable=0, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0, if_pred_taken=0.
- Issue rule: mem_renable = !rst && !redirect_valid && (count + inflight - pop) < FIFO_DEPTH.
  - pop = if_valid && if_ready.
  - On issue: inflight<=1, inflight_pc<=pc, pc<=next_pc.
  - Otherwise: inflight<=0, pc holds.
- next_pc = pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Return: when inflight=1 (and no kill), push {mem_rdata, inflight_pc, pred} into the FIFO the cycle after issue.
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - The issue rule guarantees no overflow.
- Output: if_valid = count!=0; if_instr/if_pc/if_pred_taken come from the FIFO head.
  - If_valid is never dropped without a pop or redirect.
  - Head fields stay stable while if_valid && !if_ready.
- Latency: first if_valid occurs 2 cycles after rst deasserts.
  - Cycle 1: issue. Cycle 2: push; if_valid from the next edge.
  - Steady state: 1 instruction/cycle with if_ready=1.
- Redirect (highest priority):
  - Flush the FIFO (if_valid=0 next cycle) and set kill: mem_rdata of the currently inflight read is dropped.
  - pc<=redirect_pc with bits [1:0] forced to 0; no issue in the redirect cycle.
  - Issue at the target the following cycle.
  - Redirect in the same cycle as a pop: the pop completes and the rest is flushed.
  - Back-to-back redirects: the last one wins.
- Reset mid-operation: inflight data is dropped; same state as power-up reset.

Optional Feature:
Macro PREDICT_EN.
- With it:
  - mem_addrpred = pc; mem_rdata_pred is predecoded combinationally in the issue cycle.
  - JAL (opcode 7'b1101111): next_pc = pc + sext J-imm.
  - B-type (7'b1100011) with imm[12]=1 (backward): next_pc = pc + sext B-imm.
  - Taken predictions set pred=1 for that instruction; pred is carried in the FIFO entry to if_pred_taken.
  - A redirect still overrides the prediction.
- Without it: mem_addrpred=0, next_pc=pc+4 always, if_pred_taken=0.

Decomposition:
- Package rv32_fetch_pkg:
  - OPC_JAL, OPC_BRANCH, NOP_INSTR=32'h0000_0013.
  - Fetch entry struct/width constants {instr[31:0], pc[31:0], pred}.
  - Immediate-extraction functions (J-imm, B-imm).
- Sub-module fetch_fifo:
  - Parameterised depth and width; synchronous rst.
  - push/pop/count outputs; first-word fall-through head.

Test Plan:
- Reset, memory word 0=32'h00500093, word 1=32'h00A00113, if_ready=1: first if_valid in cycle 2, if_pc=0 then 4; mem_renable asserted every cycle.
- if_ready=0 for 5 cycles: FIFO fills to 2, mem_renable drops to 0, if_instr at pc=0 held stable. Release: pcs 0,4,8 delivered in order with no gaps or duplicates.
- redirect_valid with redirect_pc=32'h100 while a read of 8 is inflight: the word at 8 never appears. Next if_pc=32'h100, and mem_addr=32'h100 one cycle after the redirect.
- redirect_pc=32'h103: fetch issues at 32'h100.
- pc=32'hFFFF_FFFC: next mem_addr=0.
- PREDICT_EN, word at 32'h10 = JAL x0,-16 (32'hFF1FF06F): mem_addr sequence 0x10, 0x00; the entry for 0x10 has if_pred_taken=1. Without the macro: 0x10, 0x14, and if_pred_taken=0.
